// File: rtl/hdlc_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared types and constants for the HDLC receive frame controller.
//   rx_state_t      : frame controller state encoding
//   HDLC_FLAG       : the opening/closing flag pattern 01111110
//   DEF_*           : default buffer capacity, FCS length and minimum frame
//   payload_size()  : byte count minus FCS, clamped at zero
// -----------------------------------------------------------------------------
package hdlc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        FRAME = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    localparam logic [7:0] HDLC_FLAG     = 8'h7E;
    localparam int         DEF_MAX_BYTES = 128;
    localparam int         DEF_FCS_BYTES = 2;
    localparam int         DEF_MIN_BYTES = 4;

    // Payload length reported to the CPU; never goes negative.
    function automatic logic [7:0] payload_size(input int count, input int fcs);
        logic [7:0] size_v;
        if (count > fcs) begin
            size_v = 8'(count - fcs);
        end else begin
            size_v = 8'd0;
        end
        return size_v;
    endfunction

endpackage

// File: rtl/hdlc_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// hdlc_rx_frame_ctrl_if
// Bundles the Rx frame controller signals.
//   master : Rx bit datapath / CPU side (drives detections, bytes, CPU acks)
//   slave  : frame controller (drives buffer writes and frame status)
// -----------------------------------------------------------------------------
interface hdlc_rx_frame_ctrl_if;

    logic       Rx_Enable;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_ReadDone;
    logic       Rx_Drop;

    logic       Rx_ValidFrame;
    logic       Rx_WrBuff;
    logic [7:0] Rx_WrData;
    logic       Rx_FlushBuff;
    logic       Rx_AbortSignal;
    logic       Rx_Overflow;
    logic       Rx_EoF;
    logic       Rx_Ready;
    logic [7:0] Rx_FrameSize;

    modport master (
        output Rx_Enable, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data,
               Rx_ReadDone, Rx_Drop,
        input  Rx_ValidFrame, Rx_WrBuff, Rx_WrData, Rx_FlushBuff, Rx_AbortSignal,
               Rx_Overflow, Rx_EoF, Rx_Ready, Rx_FrameSize
    );

    modport slave (
        input  Rx_Enable, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data,
               Rx_ReadDone, Rx_Drop,
        output Rx_ValidFrame, Rx_WrBuff, Rx_WrData, Rx_FlushBuff, Rx_AbortSignal,
               Rx_Overflow, Rx_EoF, Rx_Ready, Rx_FrameSize
    );

endinterface

// File: rtl/hdlc_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// hdlc_rx_frame_ctrl
// Frame-level controller of the HDLC receive path. Tracks frame boundaries from
// flag/abort detections, writes de-stuffed bytes into the Rx buffer, counts and
// bounds the frame length, and hands complete frames to the CPU.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   rx       : slave side of hdlc_rx_frame_ctrl_if (all outputs registered,
//              one cycle after the causing input)
// -----------------------------------------------------------------------------
module hdlc_rx_frame_ctrl
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int FCS_BYTES = DEF_FCS_BYTES,
    parameter int MIN_BYTES = DEF_MIN_BYTES
) (
    input  logic                 Clk,
    input  logic                 Rst,
    hdlc_rx_frame_ctrl_if.slave  rx
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    rx_state_t   state_q,   state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] cnt_inc_s;
    logic        valid_q,   valid_d;
    logic        wr_q,      wr_d;
    logic [7:0]  wrdata_q,  wrdata_d;
    logic        flush_q,   flush_d;
    logic        abort_q,   abort_d;
    logic        ovf_q,     ovf_d;
    logic        eof_q,     eof_d;
    logic        ready_q,   ready_d;
    logic [7:0]  size_q,    size_d;

    // Next-state and next-output logic for the frame controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc_s = cnt_q;
        wr_d      = 1'b0;
        wrdata_d  = wrdata_q;
        flush_d   = 1'b0;
        abort_d   = 1'b0;
        ovf_d     = ovf_q;
        eof_d     = 1'b0;
        ready_d   = ready_q;
        size_d    = size_q;

        if (!rx.Rx_Enable) begin
            // Disabling mid-frame discards the partial frame quietly.
            state_d = IDLE;
            ready_d = 1'b0;
            if (state_q == FRAME) begin
                flush_d = 1'b1;
            end else begin
                flush_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                end
                HUNT: begin
                    if (rx.Rx_FlagDetect) begin
                        state_d = FRAME;
                        cnt_d   = {CW{1'b0}};
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                FRAME: begin
                    if (rx.Rx_AbortDetect) begin
                        // Abort wins over any coincident byte or flag.
                        abort_d = 1'b1;
                        flush_d = 1'b1;
                        state_d = HUNT;
                    end else begin
                        // A coincident byte is counted before the flag is judged.
                        if (rx.Rx_NewByte) begin
                            if (cnt_q < CW'(MAX_BYTES)) begin
                                wr_d      = 1'b1;
                                wrdata_d  = rx.Rx_Data;
                                cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            cnt_inc_s = cnt_q;
                        end
                        cnt_d = cnt_inc_s;

                        if (rx.Rx_FlagDetect) begin
                            if (cnt_inc_s == {CW{1'b0}}) begin
                                // Back-to-back or idle flags: nothing to close.
                                state_d = FRAME;
                            end else if (cnt_inc_s < CW'(MIN_BYTES)) begin
                                // Runt frame; the same flag opens the next one.
                                flush_d = 1'b1;
                                cnt_d   = {CW{1'b0}};
                                state_d = FRAME;
                            end else begin
                                eof_d   = 1'b1;
                                size_d  = payload_size(int'(cnt_inc_s), FCS_BYTES);
                                ready_d = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            state_d = FRAME;
                        end
                    end
                end
                DONE: begin
                    // Line activity is ignored until the CPU releases the buffer.
                    if (rx.Rx_ReadDone || rx.Rx_Drop) begin
                        flush_d = 1'b1;
                        ready_d = 1'b0;
                        state_d = HUNT;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            endcase
        end

        valid_d = (state_d == FRAME);
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            valid_q  <= 1'b0;
            wr_q     <= 1'b0;
            wrdata_q <= 8'd0;
            flush_q  <= 1'b0;
            abort_q  <= 1'b0;
            ovf_q    <= 1'b0;
            eof_q    <= 1'b0;
            ready_q  <= 1'b0;
            size_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            wrdata_q <= wrdata_d;
            flush_q  <= flush_d;
            abort_q  <= abort_d;
            ovf_q    <= ovf_d;
            eof_q    <= eof_d;
            ready_q  <= ready_d;
            size_q   <= size_d;
        end
    end

    assign rx.Rx_ValidFrame  = valid_q;
    assign rx.Rx_WrBuff      = wr_q;
    assign rx.Rx_WrData      = wrdata_q;
    assign rx.Rx_FlushBuff   = flush_q;
    assign rx.Rx_AbortSignal = abort_q;
    assign rx.Rx_Overflow    = ovf_q;
    assign rx.Rx_EoF         = eof_q;
    assign rx.Rx_Ready       = ready_q;
    assign rx.Rx_FrameSize   = size_q;

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_frame_ctrl
// Directed bench for hdlc_rx_frame_ctrl. Inputs are applied 1 time unit after
// a rising edge; outputs are observed 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_hdlc_rx_frame_ctrl;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;
    int   wr_seen;

    hdlc_rx_frame_ctrl_if rx_if ();

    hdlc_rx_frame_ctrl dut (
        .Clk (clk),
        .Rst (rst),
        .rx  (rx_if)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One cycle with the given input pulses.
    task automatic step(input logic fl, input logic ab, input logic nb,
                        input logic [7:0] d, input logic rd, input logic dr);
        rx_if.Rx_FlagDetect  = fl;
        rx_if.Rx_AbortDetect = ab;
        rx_if.Rx_NewByte     = nb;
        rx_if.Rx_Data        = d;
        rx_if.Rx_ReadDone    = rd;
        rx_if.Rx_Drop        = dr;
        @(posedge clk);
        #1;
        rx_if.Rx_FlagDetect  = 1'b0;
        rx_if.Rx_AbortDetect = 1'b0;
        rx_if.Rx_NewByte     = 1'b0;
        rx_if.Rx_ReadDone    = 1'b0;
        rx_if.Rx_Drop        = 1'b0;
    endtask

    task automatic flag_in();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle_in();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Stimulus and checks.
    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1;
        rx_if.Rx_Enable = 1'b0;
        rx_if.Rx_Data   = 8'h00;
        idle_in();
        idle_in();

        // Reset state
        check_val("rst_valid", int'(rx_if.Rx_ValidFrame), 0);
        check_val("rst_wr",    int'(rx_if.Rx_WrBuff), 0);
        check_val("rst_flush", int'(rx_if.Rx_FlushBuff), 0);
        check_val("rst_abort", int'(rx_if.Rx_AbortSignal), 0);
        check_val("rst_eof",   int'(rx_if.Rx_EoF), 0);
        check_val("rst_ready", int'(rx_if.Rx_Ready), 0);
        check_val("rst_size",  int'(rx_if.Rx_FrameSize), 0);
        check_val("rst_ovf",   int'(rx_if.Rx_Overflow), 0);

        rst = 1'b0;
        rx_if.Rx_Enable = 1'b1;
        idle_in();                       // IDLE -> HUNT

        // Five-byte frame
        flag_in();
        check_val("t1_valid", int'(rx_if.Rx_ValidFrame), 1);
        for (int i = 1; i <= 5; i++) begin
            byte_in(8'(i));
            check_val("t1_wr",     int'(rx_if.Rx_WrBuff), 1);
            check_val("t1_wrdata", int'(rx_if.Rx_WrData), i);
        end
        flag_in();
        check_val("t1_eof",   int'(rx_if.Rx_EoF), 1);
        check_val("t1_size",  int'(rx_if.Rx_FrameSize), 3);
        check_val("t1_ready", int'(rx_if.Rx_Ready), 1);
        check_val("t1_ovf",   int'(rx_if.Rx_Overflow), 0);
        check_val("t1_valid", int'(rx_if.Rx_ValidFrame), 0);
        idle_in();
        check_val("t1_eof_pulse", int'(rx_if.Rx_EoF), 0);

        // Traffic in DONE is ignored, then Drop
        wr_seen = 0;
        flag_in();
        wr_seen += int'(rx_if.Rx_EoF);
        for (int i = 0; i < 4; i++) begin
            byte_in(8'hA0);
            wr_seen += int'(rx_if.Rx_WrBuff);
        end
        flag_in();
        wr_seen += int'(rx_if.Rx_EoF) + int'(rx_if.Rx_WrBuff);
        check_val("t5_no_activity", wr_seen, 0);
        check_val("t5_ready_held",  int'(rx_if.Rx_Ready), 1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_val("t5_flush", int'(rx_if.Rx_FlushBuff), 1);
        check_val("t5_ready", int'(rx_if.Rx_Ready), 0);
        check_val("t5_size",  int'(rx_if.Rx_FrameSize), 3);
        idle_in();
        check_val("t5_flush_pulse", int'(rx_if.Rx_FlushBuff), 0);

        // Abort after three bytes
        flag_in();
        for (int i = 0; i < 3; i++) byte_in(8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("t2_abort", int'(rx_if.Rx_AbortSignal), 1);
        check_val("t2_flush", int'(rx_if.Rx_FlushBuff), 1);
        check_val("t2_valid", int'(rx_if.Rx_ValidFrame), 0);
        check_val("t2_eof",   int'(rx_if.Rx_EoF), 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("t2_abort_hunt", int'(rx_if.Rx_AbortSignal), 0);
        byte_in(8'h22);
        check_val("t2_hunt_nowr", int'(rx_if.Rx_WrBuff), 0);

        // Overflow frame: 130 bytes
        flag_in();
        wr_seen = 0;
        for (int i = 1; i <= 130; i++) begin
            byte_in(8'(i));
            wr_seen += int'(rx_if.Rx_WrBuff);
            if (i == 128) begin
                check_val("t3_ovf_128", int'(rx_if.Rx_Overflow), 0);
                check_val("t3_wr_128",  int'(rx_if.Rx_WrBuff), 1);
            end
            if (i == 129) begin
                check_val("t3_ovf_129", int'(rx_if.Rx_Overflow), 1);
                check_val("t3_wr_129",  int'(rx_if.Rx_WrBuff), 0);
            end
        end
        check_val("t3_wr_count", wr_seen, 128);
        flag_in();
        check_val("t3_eof",  int'(rx_if.Rx_EoF), 1);
        check_val("t3_size", int'(rx_if.Rx_FrameSize), 126);
        check_val("t3_ovf",  int'(rx_if.Rx_Overflow), 1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_val("t3_rd_flush", int'(rx_if.Rx_FlushBuff), 1);
        check_val("t3_rd_ready", int'(rx_if.Rx_Ready), 0);

        // Runt frame followed by a real one
        flag_in();
        check_val("t4_ovf_clear", int'(rx_if.Rx_Overflow), 0);
        byte_in(8'h31);
        byte_in(8'h32);
        flag_in();
        check_val("t4_runt_flush", int'(rx_if.Rx_FlushBuff), 1);
        check_val("t4_runt_eof",   int'(rx_if.Rx_EoF), 0);
        check_val("t4_runt_valid", int'(rx_if.Rx_ValidFrame), 1);
        flag_in();                       // shared flag, count 0
        check_val("t4_idle_flush", int'(rx_if.Rx_FlushBuff), 0);
        check_val("t4_idle_eof",   int'(rx_if.Rx_EoF), 0);
        check_val("t4_idle_valid", int'(rx_if.Rx_ValidFrame), 1);
        for (int i = 0; i < 4; i++) byte_in(8'h40);
        flag_in();
        check_val("t4_eof",  int'(rx_if.Rx_EoF), 1);
        check_val("t4_size", int'(rx_if.Rx_FrameSize), 2);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check_val("t4_both_flush", int'(rx_if.Rx_FlushBuff), 1);
        check_val("t4_both_ready", int'(rx_if.Rx_Ready), 0);
        idle_in();
        check_val("t4_both_once", int'(rx_if.Rx_FlushBuff), 0);

        // Byte and closing flag together: byte counted first (4 -> size 2)
        flag_in();
        for (int i = 0; i < 3; i++) byte_in(8'h50);
        step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        check_val("sim_wr",     int'(rx_if.Rx_WrBuff), 1);
        check_val("sim_wrdata", int'(rx_if.Rx_WrData), 8'h5A);
        check_val("sim_eof",    int'(rx_if.Rx_EoF), 1);
        check_val("sim_size",   int'(rx_if.Rx_FrameSize), 2);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Abort together with a byte: abort wins
        flag_in();
        byte_in(8'h61);
        step(1'b0, 1'b1, 1'b1, 8'h62, 1'b0, 1'b0);
        check_val("abw_wr",    int'(rx_if.Rx_WrBuff), 0);
        check_val("abw_abort", int'(rx_if.Rx_AbortSignal), 1);

        // Disable mid-frame: flush, no abort
        flag_in();
        byte_in(8'h71);
        rx_if.Rx_Enable = 1'b0;
        idle_in();
        check_val("dis_flush", int'(rx_if.Rx_FlushBuff), 1);
        check_val("dis_abort", int'(rx_if.Rx_AbortSignal), 0);
        check_val("dis_valid", int'(rx_if.Rx_ValidFrame), 0);
        rx_if.Rx_Enable = 1'b1;
        idle_in();                       // IDLE -> HUNT

        // Reset mid-frame
        flag_in();
        byte_in(8'h81);
        byte_in(8'h82);
        rst = 1'b1;
        byte_in(8'h83);
        check_val("mrst_valid", int'(rx_if.Rx_ValidFrame), 0);
        check_val("mrst_wr",    int'(rx_if.Rx_WrBuff), 0);
        check_val("mrst_wdata", int'(rx_if.Rx_WrData), 0);
        check_val("mrst_flush", int'(rx_if.Rx_FlushBuff), 0);
        check_val("mrst_abort", int'(rx_if.Rx_AbortSignal), 0);
        rst = 1'b0;
        rx_if.Rx_Enable = 1'b0;
        flag_in();
        check_val("mrst_flag_ign", int'(rx_if.Rx_ValidFrame), 0);
        rx_if.Rx_Enable = 1'b1;
        flag_in();                       // still IDLE: moves to HUNT only
        check_val("mrst_idle_flag", int'(rx_if.Rx_ValidFrame), 0);
        flag_in();
        check_val("mrst_hunt_flag", int'(rx_if.Rx_ValidFrame), 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_frame_ctrl.md
Name: hdlc_rx_frame_ctrl

Overview:
Frame-level controller for the HDLC receive path. Consumes flag/abort detections and assembled bytes from the Rx bit datapath, and owns Rx_ValidFrame. It also sequences writes into the Rx frame buffer, counts frame length, detects overflow, and hands completed frames to the CPU-side register interface via Rx_Ready/Rx_EoF.

Parameters:
MAX_BYTES, 128, Rx buffer capacity in bytes (FCS included).
FCS_BYTES, 2, trailing FCS bytes excluded from the reported frame size.
MIN_BYTES, 4, minimum bytes (incl. FCS) for a frame to be accepted; shorter frames are silently flushed.

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
Rx_Enable  in  1  receiver enable from control register
Rx_FlagDetect  in  1  1-cycle pulse, flag 01111110 recognised
Rx_AbortDetect  in  1  1-cycle pulse, 7+ consecutive ones recognised
Rx_NewByte  in  1  1-cycle strobe, de-stuffed byte valid on Rx_Data
Rx_Data  in  8  assembled byte
Rx_ReadDone  in  1  1-cycle pulse, CPU finished reading the frame
Rx_Drop  in  1  1-cycle pulse, CPU discards the frame
Rx_ValidFrame  out  1  high while inside an accepted frame
Rx_WrBuff  out  1  1-cycle buffer write strobe
Rx_WrData  out  8  byte accompanying Rx_WrBuff
Rx_FlushBuff  out  1  1-cycle pulse, reset buffer write pointer
Rx_AbortSignal  out  1  1-cycle pulse, frame aborted
Rx_Overflow  out  1  sticky per frame, buffer capacity exceeded
Rx_EoF  out  1  1-cycle pulse, frame completed
Rx_Ready  out  1  frame available to CPU
Rx_FrameSize  out  8  payload bytes = count - FCS_BYTES, saturating at 0

Behaviour:
- Reset: state IDLE; every output 0; byte counter 0.
- All outputs are registered. Every response appears on the cycle after the causing input (1-cycle latency).
- States: IDLE, HUNT, FRAME, DONE.
- IDLE: Rx_Enable=1 -> HUNT.
- Rx_Enable=0 in any state -> IDLE next cycle. If leaving FRAME, also pulse Rx_FlushBuff and drop ValidFrame; no AbortSignal.
- HUNT: FlagDetect -> FRAME; count:=0; Overflow:=0. NewByte and AbortDetect are ignored.
- FRAME: Rx_ValidFrame=1.
  - NewByte with count<MAX_BYTES -> WrBuff=1, WrData=Rx_Data, count+1.
  - NewByte with count>=MAX_BYTES -> no write; Overflow:=1 (sticky until next frame start).
- FRAME + FlagDetect:
  - count=0: shared/idle flags; stay in FRAME, no outputs.
  - 0<count<MIN_BYTES: FlushBuff pulse; count:=0; stay in FRAME, since this flag opens the next frame.
  - count>=MIN_BYTES: EoF pulse; FrameSize latched; Ready:=1; ValidFrame:=0; -> DONE.
- FRAME + AbortDetect: AbortSignal pulse, FlushBuff pulse, ValidFrame:=0 on the next cycle; -> HUNT. Abort outside FRAME is ignored; AbortSignal stays 0.
- Simultaneous NewByte and FlagDetect in FRAME: the byte is written and counted first, then the flag is evaluated against the incremented count.
- Simultaneous AbortDetect with NewByte or FlagDetect: abort wins; no write, no EoF.
- DONE: Ready=1; FrameSize and Overflow held.
  - Flags, bytes and aborts are ignored; any frame arriving now is lost.
  - ReadDone or Drop: FlushBuff pulse, Ready:=0, FrameSize held -> HUNT.
  - ReadDone and Drop together behave as one event.
- Overflowed frames still complete normally via EoF. Overflow=1 tells the CPU the data is invalid. FrameSize reports MAX_BYTES-FCS_BYTES.
- Counter width is $clog2(MAX_BYTES+1). It never wraps; it saturates at MAX_BYTES.
- Rst asserted mid-frame: all state and outputs return to reset values on the next edge; no FlushBuff or AbortSignal pulse.

Decomposition:
- hdlc_pkg: rx_state_t enum (IDLE, HUNT, FRAME, DONE), HDLC_FLAG=8'h7E, default MAX_BYTES/FCS_BYTES/MIN_BYTES constants.
- Single module, no sub-module. The byte counter/overflow logic is small enough to stay inline.

Test Plan:
- Enable, flag, bytes 01,02,03,04,05, flag -> five WrBuff pulses with matching WrData; EoF 1 cycle after the closing flag; FrameSize=3; Ready=1; Overflow=0.
- Flag, 3 bytes, AbortDetect -> AbortSignal and FlushBuff exactly 1 cycle later; ValidFrame low the same cycle; no EoF; state HUNT.
- Flag, 130 bytes, flag -> exactly 128 WrBuff pulses; Overflow=1 from byte 129; EoF with FrameSize=126.
- Flag, 2 bytes, flag, 4 bytes, flag -> FlushBuff after the first closing flag; no EoF for the short frame; second frame EoF with FrameSize=2.
- In DONE, send a full frame, then Rx_Drop -> no WrBuff/EoF during DONE; FlushBuff pulse; Ready=0; back in HUNT.
- Assert Rst mid-frame after 2 bytes -> all outputs 0 next cycle; next flag is ignored until Rx_Enable is seen in IDLE.
